// File: rtl/block_spawner_if.sv
// ------------------------------------------------------------------
// block_spawner_if : control/status bundle of the falling-block scheduler
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface block_spawner_if #(
   parameter int LANE_COUNT = 4
);
   logic                    frame_tick;
   logic                    run;
   logic [LANE_COUNT-1:0]   hit;
   logic [LANE_COUNT-1:0]   block_active;
   logic [10*LANE_COUNT-1:0] block_y;
   logic [15:0]             score;
   logic [3:0]              misses;
   logic                    game_over;
   logic [1:0]              state;

   modport master (
      output frame_tick, run, hit,
      input  block_active, block_y, score, misses, game_over, state
   );

   modport slave (
      input  frame_tick, run, hit,
      output block_active, block_y, score, misses, game_over, state
   );
endinterface

`default_nettype wire

// File: rtl/block_spawner.sv
// ------------------------------------------------------------------
// block_spawner : lane scheduler that spawns, drops and retires falling blocks
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module block_spawner #(
   parameter int         LANE_COUNT   = 4,
   parameter int         SPAWN_PERIOD = 30,
   parameter int         FALL_STEP    = 2,
   parameter int         Y_MAX        = 479,
   parameter int         MAX_MISSES   = 3,
   parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
   input  logic            Clk,
   input  logic            Reset,
   block_spawner_if.slave  bus
);
   localparam int LW = $clog2(LANE_COUNT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_OVER  = 2'b11
   } state_t;

   state_t                state_q, state_d;
   logic [LANE_COUNT-1:0] active_q, active_d;
   logic [9:0]            y_q [LANE_COUNT];
   logic [9:0]            y_d [LANE_COUNT];
   logic [15:0]           score_q, score_d;
   logic [3:0]            misses_q, misses_d;
   logic                  game_over_q, game_over_d;
   logic [7:0]            lfsr_q, lfsr_d;
   logic [7:0]            spawn_cnt_q, spawn_cnt_d;

   logic [10:0]           sum;
   logic [3:0]            hcnt, mcnt;
   logic [16:0]           ssum;
   logic [4:0]            msum;
   logic                  found;
   logic [LW-1:0]         idx;

   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      y_d         = y_q;
      score_d     = score_q;
      misses_d    = misses_q;
      game_over_d = game_over_q;
      lfsr_d      = lfsr_q;
      spawn_cnt_d = spawn_cnt_q;
      sum         = '0;
      hcnt        = '0;
      mcnt        = '0;
      ssum        = '0;
      msum        = '0;
      found       = 1'b0;
      idx         = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.run) begin
               state_d     = S_RUN;
               spawn_cnt_d = '0;
            end
         end
         S_RUN: begin
            if (!bus.run) begin
               state_d = S_PAUSE;
            end else begin
               // Hits win over both movement and bottom retirement.
               for (int i = 0; i < LANE_COUNT; i++) begin
                  sum = {1'b0, y_q[i]} + 11'(FALL_STEP);
                  if (bus.hit[i] && active_q[i]) begin
                     active_d[i] = 1'b0;
                     y_d[i]      = '0;
                     hcnt        = hcnt + 4'd1;
                  end else if (bus.frame_tick && active_q[i]) begin
                     if (sum > 11'(Y_MAX)) begin
                        active_d[i] = 1'b0;
                        y_d[i]      = '0;
                        mcnt        = mcnt + 4'd1;
                     end else begin
                        y_d[i] = sum[9:0];
                     end
                  end
               end

               if (bus.frame_tick) begin
                  if (spawn_cnt_q == 8'd0) begin
                     // Only lanes free before this tick are eligible.
                     for (int k = 0; k < LANE_COUNT; k++) begin
                        idx = lfsr_q[LW-1:0] + LW'(k);
                        if (!found && !active_q[idx]) begin
                           found         = 1'b1;
                           active_d[idx] = 1'b1;
                           y_d[idx]      = '0;
                        end
                     end
                     spawn_cnt_d = 8'(SPAWN_PERIOD - 1);
                  end else begin
                     spawn_cnt_d = spawn_cnt_q - 8'd1;
                  end
                  lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
               end

               ssum    = {1'b0, score_q} + {13'd0, hcnt};
               score_d = ssum[16] ? 16'hFFFF : ssum[15:0];
               msum    = {1'b0, misses_q} + {1'b0, mcnt};
               misses_d = (msum > 5'd15) ? 4'hF : msum[3:0];
               if (msum >= 5'(MAX_MISSES)) begin
                  state_d     = S_OVER;
                  game_over_d = 1'b1;
               end
            end
         end
         S_PAUSE: begin
            if (bus.run) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_OVER;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q     <= S_IDLE;
         active_q    <= '0;
         for (int i = 0; i < LANE_COUNT; i++) begin
            y_q[i] <= '0;
         end
         score_q     <= '0;
         misses_q    <= '0;
         game_over_q <= 1'b0;
         lfsr_q      <= LFSR_SEED;
         spawn_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         y_q         <= y_d;
         score_q     <= score_d;
         misses_q    <= misses_d;
         game_over_q <= game_over_d;
         lfsr_q      <= lfsr_d;
         spawn_cnt_q <= spawn_cnt_d;
      end
   end

   assign bus.block_active = active_q;
   assign bus.score        = score_q;
   assign bus.misses       = misses_q;
   assign bus.game_over    = game_over_q;
   assign bus.state        = state_q;

   for (genvar gi = 0; gi < LANE_COUNT; gi++) begin : g_ypack
      assign bus.block_y[10*gi +: 10] = y_q[gi];
   end

endmodule

`default_nettype wire

// File: tb/tb_block_spawner.sv
// ------------------------------------------------------------------
// tb_block_spawner : directed vectors and corner sequences for block_spawner
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_block_spawner;
   logic Clk = 1'b0;
   logic Reset = 1'b0;
   always #5 Clk = ~Clk;

   block_spawner_if #(.LANE_COUNT(4)) bus1 ();
   block_spawner_if #(.LANE_COUNT(4)) bus2 ();

   block_spawner #(.LANE_COUNT(4)) dut1 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus1)
   );

   block_spawner #(.LANE_COUNT(4), .SPAWN_PERIOD(1)) dut2 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus2)
   );

   typedef struct {
      logic        run;
      logic        tick;
      logic [3:0]  hit;
      logic [1:0]  st;
      logic [3:0]  act;
      logic [39:0] y;
      logic [15:0] score;
      logic [3:0]  miss;
   } vec_t;

   vec_t tbl [11];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc1(input logic r, input logic t, input logic [3:0] h);
      bus1.run = r; bus1.frame_tick = t; bus1.hit = h;
      @(posedge Clk); #1;
      bus1.frame_tick = 1'b0; bus1.hit = '0;
   endtask

   task automatic cyc2(input logic r, input logic t, input logic [3:0] h);
      bus2.run = r; bus2.frame_tick = t; bus2.hit = h;
      @(posedge Clk); #1;
      bus2.frame_tick = 1'b0; bus2.hit = '0;
   endtask

   task automatic do_reset(input logic r1);
      Reset = 1'b0;
      bus1.run = r1; bus1.frame_tick = r1; bus1.hit = {4{r1}};
      bus2.run = 1'b0; bus2.frame_tick = 1'b0; bus2.hit = '0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b1;
      bus1.run = 1'b0; bus1.frame_tick = 1'b0; bus1.hit = '0;
   endtask

   function automatic logic [9:0] y_of(input logic [39:0] v, input int l);
      return v[10*l +: 10];
   endfunction

   function automatic logic [39:0] ymask(input logic [3:0] a);
      logic [39:0] m;
      m = '0;
      for (int l = 0; l < 4; l++) if (a[l]) m[10*l +: 10] = 10'h3FF;
      return m;
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   logic [7:0]  lfsr_m;
   logic [1:0]  cand;
   int          exp_l;
   logic [39:0] y_hold;

   initial begin
      bus1.run = 1'b0; bus1.frame_tick = 1'b0; bus1.hit = '0;
      bus2.run = 1'b0; bus2.frame_tick = 1'b0; bus2.hit = '0;

      //              run   tick  hit    st     act      y           score  miss
      tbl[0]  = '{1'b0, 1'b0, 4'h0, 2'd0, 4'b0000, 40'h0,     16'd0, 4'd0};
      tbl[1]  = '{1'b1, 1'b1, 4'h0, 2'd1, 4'b0000, 40'h0,     16'd0, 4'd0};
      tbl[2]  = '{1'b1, 1'b1, 4'h0, 2'd1, 4'b0010, 40'h0,     16'd0, 4'd0};
      tbl[3]  = '{1'b1, 1'b1, 4'h0, 2'd1, 4'b0010, 40'h800,   16'd0, 4'd0};
      tbl[4]  = '{1'b1, 1'b0, 4'h1, 2'd1, 4'b0010, 40'h800,   16'd0, 4'd0};
      tbl[5]  = '{1'b1, 1'b0, 4'h2, 2'd1, 4'b0000, 40'h0,     16'd1, 4'd0};
      tbl[6]  = '{1'b1, 1'b0, 4'h2, 2'd1, 4'b0000, 40'h0,     16'd1, 4'd0};
      tbl[7]  = '{1'b0, 1'b0, 4'h0, 2'd2, 4'b0000, 40'h0,     16'd1, 4'd0};
      tbl[8]  = '{1'b0, 1'b1, 4'hF, 2'd2, 4'b0000, 40'h0,     16'd1, 4'd0};
      tbl[9]  = '{1'b1, 1'b0, 4'h0, 2'd1, 4'b0000, 40'h0,     16'd1, 4'd0};
      tbl[10] = '{1'b1, 1'b1, 4'h0, 2'd1, 4'b0000, 40'h0,     16'd1, 4'd0};

      do_reset(1'b0);
      for (int v = 0; v < 11; v++) begin
         cyc1(tbl[v].run, tbl[v].tick, tbl[v].hit);
         chk($sformatf("vec%0d_state", v), bus1.state, tbl[v].st);
         chk($sformatf("vec%0d_active", v), bus1.block_active, tbl[v].act);
         chk($sformatf("vec%0d_y", v), bus1.block_y & ymask(tbl[v].act), tbl[v].y);
         chk($sformatf("vec%0d_score", v), bus1.score, tbl[v].score);
         chk($sformatf("vec%0d_misses", v), bus1.misses, tbl[v].miss);
         chk($sformatf("vec%0d_gover", v), bus1.game_over, 1'b0);
      end

      // Reset priority over run/tick/hit, then normal fall with a pause.
      do_reset(1'b1);
      chk("rst_state", bus1.state, 2'd0);
      chk("rst_active", bus1.block_active, 4'b0000);
      chk("rst_y", bus1.block_y, 40'h0);
      chk("rst_score", bus1.score, 16'd0);
      cyc1(1'b1, 1'b0, 4'h0);
      chk("t1_run", bus1.state, 2'd1);
      lfsr_m = 8'hA5;
      for (int k = 1; k <= 241; k++) begin
         if (k == 21) begin
            cyc1(1'b0, 1'b0, 4'h0);
            chk("t1_pause_state", bus1.state, 2'd2);
            y_hold = bus1.block_y;
            repeat (50) cyc1(1'b0, 1'b1, 4'b1111);
            chk("t1_pause_y", bus1.block_y, y_hold);
            chk("t1_pause_score", bus1.score, 16'd0);
            chk("t1_pause_active", bus1.block_active, 4'b0010);
            cyc1(1'b1, 1'b0, 4'h0);
            chk("t1_resume_state", bus1.state, 2'd1);
            chk("t1_resume_y", bus1.block_y, y_hold);
         end
         cand   = lfsr_m[1:0];
         lfsr_m = lfsr_next(lfsr_m);
         cyc1(1'b1, 1'b1, 4'h0);
         if (k == 1) chk("t1_spawn_first", bus1.block_active, 4'b0010);
         if (k == 30) chk("t1_no_spawn30", bus1.block_active, 4'b0010);
         if (k == 31) begin
            exp_l = (cand == 2'd1) ? 2 : int'(cand);
            chk("t1_spawn31", bus1.block_active, 4'b0010 | (4'b0001 << exp_l));
         end
         if (k <= 240) begin
            chk($sformatf("t1_y1_k%0d", k), y_of(bus1.block_y, 1), 10'(2 * (k - 1)));
            if (k == 240) chk("t1_miss_before", bus1.misses, 4'd0);
         end else begin
            chk("t1_lane1_retired", bus1.block_active[1], 1'b0);
            chk("t1_misses", bus1.misses, 4'd1);
            chk("t1_state_run", bus1.state, 2'd1);
         end
      end

      // Hit and bottom crossing on the same tick.
      do_reset(1'b0);
      cyc1(1'b1, 1'b0, 4'h0);
      repeat (240) cyc1(1'b1, 1'b1, 4'h0);
      chk("t2_y478", y_of(bus1.block_y, 1), 10'd478);
      cyc1(1'b1, 1'b1, 4'b0010);
      chk("t2_cleared", bus1.block_active[1], 1'b0);
      chk("t2_score", bus1.score, 16'd1);
      chk("t2_misses", bus1.misses, 4'd0);

      // Hit between ticks at y=20, then a repeat on the now-empty lane.
      do_reset(1'b0);
      cyc1(1'b1, 1'b0, 4'h0);
      repeat (11) cyc1(1'b1, 1'b1, 4'h0);
      chk("t3_y20", y_of(bus1.block_y, 1), 10'd20);
      cyc1(1'b1, 1'b0, 4'b0010);
      chk("t3_cleared", bus1.block_active[1], 1'b0);
      chk("t3_score1", bus1.score, 16'd1);
      cyc1(1'b1, 1'b0, 4'b0010);
      chk("t3_score_hold", bus1.score, 16'd1);
      do_reset(1'b0);
      chk("t3_midrst_state", bus1.state, 2'd0);
      chk("t3_midrst_score", bus1.score, 16'd0);

      // Every-tick spawning fills all lanes, then three misses end the game.
      do_reset(1'b0);
      cyc2(1'b1, 1'b0, 4'h0);
      cyc2(1'b1, 1'b1, 4'h0);
      chk("t4_fill1", bus2.block_active, 4'b0010);
      cyc2(1'b1, 1'b1, 4'h0);
      chk("t4_fill2", bus2.block_active, 4'b0110);
      cyc2(1'b1, 1'b1, 4'h0);
      chk("t4_fill3", bus2.block_active, 4'b1110);
      cyc2(1'b1, 1'b1, 4'h0);
      chk("t4_fill4", bus2.block_active, 4'b1111);
      chk("t4_y4", bus2.block_y, (40'd2 << 30) | (40'd4 << 20) | (40'd6 << 10));
      cyc2(1'b1, 1'b1, 4'h0);
      chk("t4_drop_active", bus2.block_active, 4'b1111);
      chk("t4_drop_y", bus2.block_y, (40'd4 << 30) | (40'd6 << 20) | (40'd8 << 10) | 40'd2);
      for (int k = 6; k <= 240; k++) cyc2(1'b1, 1'b1, 4'h0);
      cyc2(1'b1, 1'b1, 4'h0);
      chk("t4_miss1", bus2.misses, 4'd1);
      chk("t4_act241", bus2.block_active, 4'b1101);
      cyc2(1'b1, 1'b1, 4'h0);
      chk("t4_miss2", bus2.misses, 4'd2);
      chk("t4_act242", bus2.block_active, 4'b1011);
      chk("t4_state242", bus2.state, 2'd1);
      cyc2(1'b1, 1'b1, 4'h0);
      chk("t4_miss3", bus2.misses, 4'd3);
      chk("t4_over", bus2.state, 2'd3);
      chk("t4_gover", bus2.game_over, 1'b1);
      chk("t4_act243", bus2.block_active, 4'b0111);
      chk("t4_y243", bus2.block_y, (40'd2 << 10) | 40'd478);
      repeat (5) cyc2(1'b1, 1'b1, 4'b1111);
      cyc2(1'b0, 1'b1, 4'h0);
      chk("t4_frz_state", bus2.state, 2'd3);
      chk("t4_frz_act", bus2.block_active, 4'b0111);
      chk("t4_frz_y", bus2.block_y, (40'd2 << 10) | 40'd478);
      chk("t4_frz_score", bus2.score, 16'd0);
      chk("t4_frz_miss", bus2.misses, 4'd3);
      do_reset(1'b0);
      chk("t4_rst_state", bus2.state, 2'd0);
      chk("t4_rst_gover", bus2.game_over, 1'b0);
      chk("t4_rst_act", bus2.block_active, 4'b0000);
      chk("t4_rst_miss", bus2.misses, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
